coin_dispenser: RTL
===================

Name: coin_dispenser

Overview:
- Change-return stage directly downstream of the vending control FSM.
- Consumes the single-cycle DROP50/DROP100/DROP500/DROP1000 pulses and queues them in a small FIFO.
- Drives one coin-tube solenoid at a time, confirms each coin via the drop sensor, and tracks per-tube inventory.
- Reports Busy, per-tube Empty flags and a sticky Fault back to the control and management logic.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2).
- PULSE_CYCLES, 8, solenoid on-time in clocks.
- TIMEOUT, 32, max clocks after solenoid release to wait for CoinSensed.
- TUBE_CAP, 50, coins per tube after reset/refill.
- CNT_W, 6, inventory counter width (2^CNT_W > TUBE_CAP).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- DROP50, DROP100, DROP500, DROP1000  in  1 each  dispense request pulses, one cycle each.
- Refill  in  1  single-cycle pulse: all tubes restocked.
- CoinSensed  in  1  drop-chute sensor, high ≥1 cycle per coin.
- SOL50, SOL100, SOL500, SOL1000  out  1 each  tube solenoid drives; at most one high at a time.
- Busy  out  1  FIFO non-empty or FSM not in IDLE.
- Empty  out  4  per-tube inventory==0; bit0=50, bit1=100, bit2=500, bit3=1000.
- Fault  out  1  sticky error flag.

Behaviour:
- Reset (sync, RST=1 at a CLK edge), after which:
  - all SOL=0, Busy=0, Empty=0, Fault=0;
  - FIFO empty, FSM=IDLE;
  - all inventory counters=TUBE_CAP.
- Reset mid-dispense aborts immediately. The solenoid drops on the next edge and no count is decremented.
- Enqueue:
  - A DROPx high at edge t writes a 2-bit code (0=50, 1=100, 2=500, 3=1000) into the FIFO.
  - More than one DROP high in the same cycle: only the highest denomination is enqueued, and Fault is set.
  - FIFO full with no pop in the same cycle: the request is discarded and Fault is set. Full with a simultaneous pop: the request is accepted.
- FSM states: IDLE, FIRE, WAIT, GAP.
  - IDLE:
    - FIFO empty: stay.
    - Otherwise pop the head.
    - If that tube's count is 0: discard the entry, set Fault, stay IDLE. The next entry is considered on the next cycle.
    - Else: go to FIRE and clear the sensed flag.
  - FIRE:
    - The selected SOLx is high for exactly PULSE_CYCLES cycles, counted by an internal timer.
    - CoinSensed seen in any FIRE cycle sets the sensed flag.
    - At the end of the pulse: go to GAP if the flag is set, else go to WAIT.
  - WAIT:
    - SOL low; a timer counts up to TIMEOUT cycles.
    - CoinSensed: decrement the tube count and go to GAP.
    - Timeout: set that tube's count to 0 (jammed/empty), set Fault, go to IDLE.
  - GAP:
    - One cycle with SOL low; go to IDLE.
    - If arriving from FIRE (sensed flag set), the tube count is decremented on the GAP cycle.
- Latency: DROPx at edge t → FIFO non-empty from t+1 → IDLE pops at edge t+1 → SOLx high for cycles t+2 … t+1+PULSE_CYCLES.
- Minimum spacing per coin: 1 (IDLE) + PULSE_CYCLES + 1 (GAP) cycles when the sensor fires during the pulse.
- Inventory counters:
  - Saturate at 0 and never decrement below zero.
  - Empty[i] = (count[i]==0), registered from the counters.
- Refill:
  - Honoured only in IDLE with the FIFO empty: all counts set to TUBE_CAP and Fault cleared.
  - Ignored otherwise, with no Fault raised.
- CoinSensed in IDLE or GAP is ignored.
- Busy is combinational from FIFO state and FSM state; it is high on the cycle after any accepted DROP.

Test Plan:
- Reset, then pulse DROP100 at cycle 10 → SOL100 high on cycles 12–19. Assert CoinSensed on cycle 15 → count100=49 after the GAP cycle, Busy low by cycle 21, Fault=0.
- DROP500 pulsed 3 times, one cycle apart, with CoinSensed in each FIRE → three 8-cycle SOL500 pulses separated by GAP+IDLE cycles, count500=47, no Fault.
- DROP50 with CoinSensed never asserted → SOL50 pulse, then WAIT for 32 cycles, then count50=0, Empty[0]=1, Fault=1. A following DROP50 is discarded in IDLE with no SOL50 pulse.
- DROP1000 and DROP50 asserted in the same cycle → only SOL1000 fires, Fault=1. Then Refill while idle → Fault=0, all counts=50, Empty=0.
- Five DROP100 pulses on consecutive cycles with DEPTH=4:
  - First pops at edge t+1, so entries 2–5 fit → all five dispense and Fault stays 0.
  - Repeat with six pulses → the sixth is discarded and Fault=1.
- RST asserted during FIRE of a DROP500 → SOL500=0 on the next edge, FIFO empty, count500=50, Busy=0.

Source files
------------

// File: rtl/coin_dispenser.sv
// Change-return stage: queues denomination requests from the vending FSM,
// fires one coin-tube solenoid at a time, confirms each coin through the
// drop-chute sensor and keeps a per-tube inventory with empty/fault reporting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | pop next request; discard it (and flag) if its tube is empty
// S_FIRE | selected solenoid held high for PULSE_CYCLES clocks
// S_WAIT | solenoid released, waiting up to TIMEOUT clocks for the coin
// S_GAP  | one quiet cycle between coins; books a coin sensed during FIRE
module coin_dispenser #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 8,
    parameter int TIMEOUT      = 32,
    parameter int TUBE_CAP     = 50,
    parameter int CNT_W        = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DROP50,
    input  logic       DROP100,
    input  logic       DROP500,
    input  logic       DROP1000,
    input  logic       Refill,
    input  logic       CoinSensed,
    output logic       SOL50,
    output logic       SOL100,
    output logic       SOL500,
    output logic       SOL1000,
    output logic       Busy,
    output logic [3:0] Empty,
    output logic       Fault
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t             state;
    logic [1:0]         sel;
    logic [3:0]         sol;
    logic [TMR_W-1:0]   timer;
    logic               sensed;
    logic [CNT_W-1:0]   count [4];
    logic [3:0]         empty_r;
    logic               fault_r;

    logic [1:0]         fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic [1:0]         head;

    logic [3:0]         drop_vec;
    logic               drop_any;
    logic               drop_multi;
    logic [1:0]         drop_code;
    logic               push;
    logic               pop;
    logic               enq_fault;

    assign drop_vec   = {DROP1000, DROP500, DROP100, DROP50};
    assign drop_any   = |drop_vec;
    assign drop_multi = (drop_vec & (drop_vec - 4'd1)) != 4'd0;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(DEPTH));
    assign head       = fifo_mem[rd_ptr];

    // a full queue still takes a request when the head leaves on the same edge
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign push      = drop_any && (!fifo_full || pop);
    assign enq_fault = drop_multi || (drop_any && fifo_full && !pop);

    // simultaneous requests collapse to the highest denomination
    always_comb begin
        drop_code = 2'd0;
        if (DROP1000)     drop_code = 2'd3;
        else if (DROP500) drop_code = 2'd2;
        else if (DROP100) drop_code = 2'd1;
    end

    // request storage; contents need no reset since occupancy gates reads
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= drop_code;
    end

    // queue pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // dispense sequencer, inventory, empty flags and sticky fault
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            sel     <= 2'd0;
            sol     <= 4'd0;
            timer   <= '0;
            sensed  <= 1'b0;
            empty_r <= 4'd0;
            fault_r <= 1'b0;
            for (int i = 0; i < 4; i++) count[i] <= CNT_W'(TUBE_CAP);
        end else begin
            for (int i = 0; i < 4; i++) empty_r[i] <= (count[i] == '0);

            case (state)
                S_IDLE: begin
                    sol <= 4'd0;
                    if (!fifo_empty) begin
                        sel <= head;
                        if (count[head] == '0) begin
                            fault_r <= 1'b1;
                        end else begin
                            state  <= S_FIRE;
                            sol    <= 4'b0001 << head;
                            timer  <= TMR_W'(PULSE_CYCLES - 1);
                            sensed <= 1'b0;
                        end
                    end else if (Refill) begin
                        for (int i = 0; i < 4; i++) count[i] <= CNT_W'(TUBE_CAP);
                        fault_r <= 1'b0;
                    end
                end
                S_FIRE: begin
                    if (timer == '0) begin
                        sol <= 4'd0;
                        if (sensed || CoinSensed) begin
                            sensed <= 1'b1;
                            state  <= S_GAP;
                        end else begin
                            timer <= TMR_W'(TIMEOUT - 1);
                            state <= S_WAIT;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                        if (CoinSensed) sensed <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (CoinSensed) begin
                        if (count[sel] != '0) count[sel] <= count[sel] - CNT_W'(1);
                        sensed <= 1'b0;
                        state  <= S_GAP;
                    end else if (timer == '0) begin
                        count[sel] <= '0;
                        fault_r    <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_GAP: begin
                    if (sensed && count[sel] != '0) count[sel] <= count[sel] - CNT_W'(1);
                    sensed <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // request-side errors win over a same-cycle refill clear
            if (enq_fault) fault_r <= 1'b1;
        end
    end

    assign SOL50   = sol[0];
    assign SOL100  = sol[1];
    assign SOL500  = sol[2];
    assign SOL1000 = sol[3];
    assign Busy    = !fifo_empty || (state != S_IDLE);
    assign Empty   = empty_r;
    assign Fault   = fault_r;

endmodule
